// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and sizing for the iterative mul/div unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  localparam logic [5:0] LAST_STEP = 6'd31;

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - 64-bit accumulator/remainder shift datapath, one step per cycle
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN-1:0] opb_q;
  logic            div_q;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rtmp;
  logic [XLEN-1:0] sub;
  logic            fits;

  // Multiply: upper half accumulates, lower half holds the shrinking multiplier.
  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
  assign rtmp    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign fits    = (rtmp >= {1'b0, opb_q});
  assign sub     = rtmp[XLEN-1:0] - opb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc   <= {{XLEN{1'b0}}, opa};
      opb_q <= opb;
      div_q <= is_div;
    end else if (step) begin
      if (div_q) begin
        if (fits)
          acc <= {sub, acc[XLEN-2:0], 1'b1};
        else
          acc <= {rtmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M iterative multiply/divide unit: FSM, sign handling and writeback handshake
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  logic [5:0]      count;
  op_e             op_in;
  op_e             op_q;
  logic            neg_q;
  logic            fast_q;
  logic [XLEN-1:0] fast_val_q;

  logic            a_signed, b_signed, neg_a, neg_b;
  logic            div_zero, div_ovf, fast, neg_res, accept;
  logic [XLEN-1:0] mag_a, mag_b, fast_val;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0] quo, rem, fixed;

  assign op_in  = op_e'(op);
  assign accept = (state == S_IDLE) && start && !kill;

  always_comb begin
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    neg_a    = a_signed && rs1_data[XLEN-1];
    neg_b    = b_signed && rs2_data[XLEN-1];
    mag_a    = neg_a ? -rs1_data : rs1_data;
    mag_b    = neg_b ? -rs2_data : rs2_data;
    neg_res  = (op_in == OP_REM) ? neg_a : (neg_a ^ neg_b);
    div_zero = is_div_op(op) && (rs2_data == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (rs1_data == MIN_INT) && (rs2_data == '1);
    fast     = div_zero || div_ovf;
    fast_val = '0;
    if (div_zero)
      fast_val = op[1] ? rs1_data : '1;
    else if (div_ovf)
      fast_val = op[1] ? '0 : MIN_INT;
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state == S_CALC),
    .is_div (is_div_op(op)),
    .opa    (mag_a),
    .opb    (mag_b),
    .acc    (acc)
  );

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       fixed = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixed = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fixed = neg_q ? -quo : quo;
      default:                      fixed = neg_q ? -rem : rem;
    endcase
    if (fast_q)
      fixed = fast_val_q;
  end

  // DONE spends one cycle on the sign fix-up and one cycle presenting the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      count      <= '0;
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
      fast_val_q <= '0;
      done       <= 1'b0;
      result     <= '0;
      rd_out     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            op_q       <= op_in;
            neg_q      <= neg_res;
            fast_q     <= fast;
            fast_val_q <= fast_val;
            rd_out     <= rd_in;
            count      <= '0;
            state      <= fast ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            count <= count + 6'd1;
            if (count == LAST_STEP)
              state <= S_DONE;
          end
        end
        S_DONE: begin
          if (kill) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end else if (!done) begin
            result <= fixed;
            done   <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign reg_write = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, reg_write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .kill      (kill),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .reg_write (reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                       input bit poke, input string tag);
    int lat;
    bit got;
    @(negedge clk);
    op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      start = 1'b0;
      if (done) got = 1'b1;
      else if (poke && lat == 5) begin
        start = 1'b1; op = MUL; rs1_data = 32'h1234; rs2_data = 32'h3; rd_in = 5'd9;
      end
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
    check({tag, "_we"}, {31'd0, reg_write}, {31'd0, rd != 5'd0});
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int dones;
    rst = 1'b0; start = 1'b0; kill = 1'b0; op = MUL;
    rs1_data = '0; rs2_data = '0; rd_in = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    check("rst_we", {31'd0, reg_write}, 32'd0);
    @(negedge clk) rst = 1'b1;

    do_op(MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, 1'b0, "mul");
    do_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33, 1'b0, "mulhu");
    do_op(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33, 1'b0, "mulh");
    do_op(MULHSU, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33, 1'b0, "mulhsu");
    do_op(DIV,    32'hFFFFFFF9, 32'd2,        5'd1,  32'hFFFFFFFD, 33, 1'b0, "div");
    do_op(REM,    32'hFFFFFFF9, 32'd2,        5'd2,  32'hFFFFFFFF, 33, 1'b0, "rem");
    do_op(DIVU,   32'd100,      32'd7,        5'd3,  32'd14,       33, 1'b1, "divu_poke");
    do_op(REMU,   32'd100,      32'd7,        5'd4,  32'd2,        33, 1'b0, "remu");
    do_op(DIV,    32'd7,        32'hFFFFFFFE, 5'd10, 32'hFFFFFFFD, 33, 1'b0, "div_negb");
    do_op(REM,    32'd7,        32'hFFFFFFFE, 5'd11, 32'd1,        33, 1'b0, "rem_negb");
    do_op(DIV,    32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1,  1'b0, "div0");
    do_op(REMU,   32'd5,        32'd0,        5'd13, 32'd5,        1,  1'b0, "remu0");
    do_op(DIV,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1,  1'b0, "div_ovf");
    do_op(REM,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1,  1'b0, "rem_ovf");
    do_op(MUL,    32'd6,        32'd7,        5'd0,  32'd42,       33, 1'b0, "mul_rd0");

    @(negedge clk);
    op = MUL; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_idle", {30'd0, busy, done}, 32'd0);
    do_op(DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 33, 1'b0, "after_kill");

    @(negedge clk);
    op = MUL; rs1_data = 32'd3; rs2_data = 32'd5; rd_in = 5'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_rd", {27'd0, rd_out}, 32'd0);
    check("mid_rst_we", {31'd0, reg_write}, 32'd0);
    @(negedge clk) rst = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("post_rst_quiet", 32'(dones), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have input clk, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have input start, 1 bit: request; sampled only in IDLE.
REQ-005 SHALL have input op, 3 bits: RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-006 SHALL have inputs rs1_data and rs2_data, XLEN bits each: operands from register-file read ports 1 and 2.
REQ-007 SHALL have input rd_in, 5 bits: destination register tag.
REQ-008 SHALL have input kill, 1 bit: abort in-flight operation (pipeline flush).
REQ-009 SHALL have output busy, 1 bit: high in CALC and DONE; drives core stall.
REQ-010 SHALL have output done, 1 bit: one-cycle result-valid pulse.
REQ-011 SHALL have output result, XLEN bits: writeback data for register-file write_data.
REQ-012 SHALL have output rd_out, 5 bits: latched rd_in for register-file rd.
REQ-013 SHALL have output reg_write, 1 bit: equals done AND (rd_out != 0), for register-file RegWrite.

Function
REQ-014 SHALL implement states IDLE, CALC and DONE.
REQ-015 SHALL, when start=1 in IDLE with kill=0, latch op, operands and rd_in at that edge and enter CALC with iteration count 0.
REQ-016 SHALL ignore start in CALC and DONE; the latched operands are not disturbed.
REQ-017 SHALL execute exactly one shift-add (multiply) or restoring shift-subtract (divide) step per cycle in CALC; after 32 steps it enters DONE.
REQ-018 SHALL, for a start sampled at edge N, hold done=1 for exactly the one cycle following edge N+33; the unit returns to IDLE at edge N+34 and accepts a new start there.
REQ-019 SHALL convert signed operands to magnitudes on entry and correct the result sign in DONE: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
REQ-020 SHALL form the 64-bit product internally; MUL returns bits [31:0] and the MULH variants return bits [63:32].
REQ-021 SHALL take the REM/REMU remainder sign from the dividend; DIV rounds toward zero.
REQ-022 SHALL handle divide by zero (rs2_data=0) as a fast path, going IDLE->DONE in one edge: DIV/DIVU return 0xFFFFFFFF and REM/REMU return rs1_data.
REQ-023 SHALL handle signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF) as a fast path: DIV returns 0x80000000, REM returns 0.
REQ-024 SHALL, on kill=1 in CALC or DONE, go to IDLE at the next edge with no done pulse; kill in IDLE has no effect, and start is ignored in any cycle where kill=1.
REQ-025 SHALL hold result and rd_out stable from DONE until the next accepted start.

Reset
REQ-026 SHALL, on rst=0, force IDLE immediately with busy=0, done=0, reg_write=0, result=0, rd_out=0 and the iteration counter at 0.
REQ-027 SHALL discard any operation in progress when reset is asserted mid-operation; no done pulse follows reset release.

Structure
REQ-028 SHALL place the op encodings and the state enum in shared package muldiv_pkg.
REQ-029 SHALL use one sub-module, muldiv_iter_core, holding the 64-bit accumulator/remainder shift datapath and performing one step per cycle; the top level holds the FSM, the sign fix-up and the handshake.

Verification
REQ-030 SHALL cover: MUL 7 x -3 -> done at N+33, result 0xFFFFFFEB.
REQ-031 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-032 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-033 SHALL cover: DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done at N+1; DIV 0x80000000/-1 -> 0x80000000.
REQ-034 SHALL cover: kill at CALC cycle 10, then start in the next cycle -> no stale done, and only the second result appears.
REQ-035 SHALL cover: rd_in=0 -> done=1 with reg_write=0; rst=0 mid-CALC -> immediate IDLE with all outputs 0.
